// File: rtl/ad9253_capture.sv
// ad9253_capture: pre/post-trigger circular capture buffer for AD9253 frames, DCO domain only.
// Define AD9253_CAPTURE_FORCE_TRIG_EN to let FORCE_TRIG fire the trigger on the next valid frame.
module ad9253_capture #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 128
) (
    input  logic                  DCO,
    input  logic                  RST,
    input  logic                  Data_VLD,
    input  logic [13:0]           Data_CH0,
    input  logic [13:0]           Data_CH1,
    input  logic [13:0]           Data_CH2,
    input  logic [13:0]           Data_CH3,
    input  logic                  ARM,
    input  logic [1:0]            TRIG_CH,
    input  logic [13:0]           TRIG_LEVEL,
    input  logic                  TRIG_EDGE,
    input  logic                  FORCE_TRIG,
    input  logic                  RD_READY,
    output logic                  RD_VALID,
    output logic [55:0]           RD_DATA,
    output logic                  RD_LAST,
    output logic [2:0]            STATE,
    output logic [DEPTH_LOG2-1:0] TRIG_ADDR,
    output logic                  DONE
);
    localparam int AW = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   PRE_N   = (AW+1)'(PRE_TRIG);
    localparam logic [AW:0]   POST_N  = (AW+1)'(DEPTH - PRE_TRIG);
    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_N  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_A   = AW'(PRE_TRIG);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_PREFILL = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_READ = 3'd4
    } state_t;

    state_t        state, nstate;
    logic [AW-1:0] wr_ptr, rd_addr;
    logic [AW:0]   cnt, rd_cnt;
    logic [13:0]   prev, cur;
    logic [55:0]   frame, ram_q;
    logic          crossing, force_hit, trig, wr_en, issue, pop, push;
    logic          rq_vld, rq_last, done;
    logic [1:0][55:0] fifo_data;
    logic [1:0]    fifo_last;
    logic          fifo_wptr, fifo_rptr;
    logic [1:0]    fifo_cnt;
    logic [55:0]   ram [DEPTH];

    assign frame = {Data_CH3, Data_CH2, Data_CH1, Data_CH0};

    always_comb begin
        case (TRIG_CH)
            2'd0:    cur = Data_CH0;
            2'd1:    cur = Data_CH1;
            2'd2:    cur = Data_CH2;
            default: cur = Data_CH3;
        endcase
    end

    assign crossing = TRIG_EDGE ? (prev >= TRIG_LEVEL && cur < TRIG_LEVEL)
                                : (prev < TRIG_LEVEL && cur >= TRIG_LEVEL);

`ifdef AD9253_CAPTURE_FORCE_TRIG_EN
    logic force_lat;
    always_ff @(posedge DCO or posedge RST) begin
        if (RST)                  force_lat <= 1'b0;
        else if (state != S_WAIT) force_lat <= 1'b0;
        else if (FORCE_TRIG)      force_lat <= 1'b1;
    end
    assign force_hit = force_lat;
`else
    logic unused_force;
    assign unused_force = FORCE_TRIG;
    assign force_hit    = 1'b0;
`endif

    assign trig = (state == S_WAIT) && Data_VLD && (crossing || force_hit);

    // Readout side: head of the 2-entry skid FIFO drives the port directly
    assign RD_VALID = (fifo_cnt != 2'd0);
    assign RD_DATA  = fifo_data[fifo_rptr];
    assign RD_LAST  = RD_VALID && fifo_last[fifo_rptr];
    assign pop      = RD_VALID && RD_READY;
    assign push     = rq_vld;
    assign DONE     = done;

    always_ff @(posedge DCO or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:    if (ARM) nstate = S_PREFILL;
            S_PREFILL: if (Data_VLD && cnt == PRE_N - 1'b1) nstate = S_WAIT;
            S_WAIT:    if (trig) nstate = S_POST;
            S_POST:    if (cnt == POST_N || (Data_VLD && cnt == POST_N - 1'b1)) nstate = S_READ;
            S_READ:    if (pop && RD_LAST) nstate = S_IDLE;
            default:   nstate = S_IDLE;
        endcase
    end

    // Reads are issued only while the FIFO plus the in-flight RAM word leave room after this pop
    always_comb begin
        STATE = state;
        wr_en = Data_VLD && (state == S_PREFILL || state == S_WAIT ||
                             (state == S_POST && cnt < POST_N));
        issue = (state == S_READ) && (rd_cnt != DEPTH_N) &&
                (({1'b0, fifo_cnt} + {2'b0, rq_vld} - {2'b0, pop}) < 3'd2);
    end

    always_ff @(posedge DCO) begin
        if (wr_en) ram[wr_ptr] <= frame;
        if (issue) ram_q <= ram[rd_addr];
    end

    always_ff @(posedge DCO or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            prev      <= '0;
            TRIG_ADDR <= '0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
            rq_vld    <= 1'b0;
            rq_last   <= 1'b0;
            fifo_data <= '0;
            fifo_last <= '0;
            fifo_wptr <= 1'b0;
            fifo_rptr <= 1'b0;
            fifo_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            if (state == S_IDLE && ARM) begin
                wr_ptr <= '0;
                cnt    <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state != S_WAIT) cnt <= cnt + 1'b1;
                else if (trig)       cnt <= (AW+1)'(1);
            end
            if (Data_VLD && (state == S_PREFILL || state == S_WAIT)) prev <= cur;
            if (trig) TRIG_ADDR <= wr_ptr;

            if (state == S_POST && nstate == S_READ) begin
                rd_addr <= TRIG_ADDR - PRE_A;
                rd_cnt  <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
            end
            rq_vld  <= issue;
            rq_last <= (rd_cnt == LAST_N);

            if (push) begin
                fifo_data[fifo_wptr] <= ram_q;
                fifo_last[fifo_wptr] <= rq_last;
                fifo_wptr            <= ~fifo_wptr;
            end
            if (pop) fifo_rptr <= ~fifo_rptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            done     <= (state == S_READ) && pop && RD_LAST;
        end
    end
endmodule

// File: tb/tb_ad9253_capture.sv
// tb_ad9253_capture: randomized bench; each capture is predicted from the list of frames delivered
// to the DUT (trigger search over that list, then window slicing) and checked on the readout port.
`timescale 1ns/1ps
module tb_ad9253_capture;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int POST  = DEPTH - PRE;

    logic        dco = 1'b0;
    logic        rst, vld, arm, trig_edge, force_trig, rd_ready;
    logic [13:0] ch0, ch1, ch2, ch3, trig_level;
    logic [1:0]  trig_ch;
    logic        rd_valid, rd_last, done;
    logic [55:0] rd_data;
    logic [2:0]  state;
    logic [3:0]  trig_addr;

    int checks = 0;
    int errors = 0;
    logic [55:0] frames[$];

    always #5 dco = ~dco;

    ad9253_capture #(.DEPTH_LOG2(4), .PRE_TRIG(PRE)) dut (
        .DCO(dco), .RST(rst), .Data_VLD(vld),
        .Data_CH0(ch0), .Data_CH1(ch1), .Data_CH2(ch2), .Data_CH3(ch3),
        .ARM(arm), .TRIG_CH(trig_ch), .TRIG_LEVEL(trig_level), .TRIG_EDGE(trig_edge),
        .FORCE_TRIG(force_trig), .RD_READY(rd_ready), .RD_VALID(rd_valid), .RD_DATA(rd_data),
        .RD_LAST(rd_last), .STATE(state), .TRIG_ADDR(trig_addr), .DONE(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge dco);
        #1;
    endtask

    function automatic logic [13:0] wave(input int sel, input int i);
        case (sel)
            0:       return 14'(i);
            1:       return (i < 40) ? 14'(50 + i) : 14'(90 - (i - 40));
            2:       return 14'($urandom);
            default: return 14'd100;
        endcase
    endfunction

    function automatic logic [13:0] pick(input logic [55:0] f);
        return f[trig_ch*14 +: 14];
    endfunction

    // First frame that satisfies the crossing rule (or the forced frame), never within the prefill
    function automatic int find_trig(input int force_idx);
        logic [13:0] p, c;
        for (int i = PRE; i < frames.size(); i++) begin
            p = pick(frames[i-1]);
            c = pick(frames[i]);
            if (force_idx >= 0 && i >= force_idx) return i;
            if (!trig_edge && p < trig_level && c >= trig_level) return i;
            if (trig_edge && p >= trig_level && c < trig_level) return i;
        end
        return -1;
    endfunction

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_state"}, 64'(state), 0);
        check({tag, "_valid"}, 64'(rd_valid), 0);
        check({tag, "_taddr"}, 64'(trig_addr), 0);
        #2 rst = 1'b0;
        tick;
    endtask

    // mode: 0 normal, 1 reset in POST, 2 reset during stalled readout, 3 FORCE_TRIG
    task automatic capture(input int sel, input int vld_pct, input int rdy_pct, input int mode);
        int force_idx = -1;
        int k, n, cyc, lat, post_seen;
        bit forced = 1'b0;
        logic [13:0] w;
        logic [55:0] d;
        logic v, l;
        frames.delete();
        // a frame arriving with ARM must not be stored
        arm = 1'b1; vld = 1'b1; {ch3, ch2, ch1, ch0} = {14'h3fff, 14'h3fff, 14'h3fff, 14'h3fff};
        tick;
        arm = 1'b0; vld = 1'b0;
        check("arm_state", 64'(state), 1);
        cyc = 0; post_seen = 0;
        while (state != 3'd4 && cyc < 4000) begin
            vld = ($urandom_range(99) < vld_pct);
            force_trig = 1'b0;
            if (mode == 3 && !forced && state == 3'd2 && frames.size() >= PRE + 3) begin
                force_trig = 1'b1; vld = 1'b0; forced = 1'b1; force_idx = frames.size();
            end
            ch0 = 14'($urandom); ch1 = 14'($urandom); ch2 = 14'($urandom); ch3 = 14'($urandom);
            w = wave(sel, frames.size());
            case (trig_ch)
                2'd0:    ch0 = w;
                2'd1:    ch1 = w;
                2'd2:    ch2 = w;
                default: ch3 = w;
            endcase
            tick;
            cyc++;
            if (vld) frames.push_back({ch3, ch2, ch1, ch0});
            if (state == 3'd3) post_seen++;
            if (mode == 1 && post_seen >= 3) break;
            if (mode == 3 && forced && frames.size() > force_idx + 20) break;
        end
        vld = 1'b0; force_trig = 1'b0;
        if (mode == 1) begin
            check("post_reached", 64'(post_seen), 3);
            async_reset("rst_post");
            return;
        end
`ifndef AD9253_CAPTURE_FORCE_TRIG_EN
        if (mode == 3) begin
            check("force_ignored", 64'(state), 2);
            async_reset("rst_force");
            return;
        end
        force_idx = -1;
`endif
        if (state != 3'd4) begin
            check("reach_readout", 64'(state), 4);
            async_reset("rst_timeout");
            return;
        end
        k = find_trig(force_idx);
        check("trig_found", 64'(k >= 0), 1);
        if (k < 0) begin
            async_reset("rst_model");
            return;
        end
        check("frames_stored", 64'(frames.size()), 64'(k + POST));
        check("trig_addr", 64'(trig_addr), 64'(k % DEPTH));

        rd_ready = 1'b0;
        lat = 0;
        while (!rd_valid && lat < 10) begin
            tick;
            lat++;
        end
        check("first_valid_lat", 64'(lat), 2);
        if (mode == 2) begin
            repeat (3) tick;
            check("stall_valid", 64'(rd_valid), 1);
            async_reset("rst_rd");
            return;
        end

        n = 0; cyc = 0;
        while (n < DEPTH && cyc < 2000) begin
            rd_ready = ($urandom_range(99) < rdy_pct);
            v = rd_valid; d = rd_data; l = rd_last;
            check("done_early", 64'(done), 0);
            tick;
            cyc++;
            if (v && rd_ready) begin
                check($sformatf("word%0d", n), d, frames[k - PRE + n]);
                check($sformatf("last%0d", n), 64'(l), 64'(n == DEPTH - 1));
                n++;
            end else if (v) begin
                check("hold_valid", 64'(rd_valid), 1);
                check("hold_data", rd_data, d);
                check("hold_last", 64'(rd_last), 64'(l));
            end
        end
        check("transfers", 64'(n), DEPTH);
        if (rdy_pct >= 100) check("burst_cycles", 64'(cyc), DEPTH);
        check("done_pulse", 64'(done), 1);
        check("idle_after", 64'(state), 0);
        rd_ready = 1'b0;
        tick;
        check("done_once", 64'(done), 0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; vld = 1'b0; force_trig = 1'b0; rd_ready = 1'b0;
        ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
        trig_ch = 2'd0; trig_level = 14'd10; trig_edge = 1'b0;
        tick;
        check("rst_state", 64'(state), 0);
        check("rst_valid", 64'(rd_valid), 0);
        check("rst_data", rd_data, 0);
        check("rst_last", 64'(rd_last), 0);
        check("rst_taddr", 64'(trig_addr), 0);
        check("rst_done", 64'(done), 0);
        rst = 1'b0;
        tick;

        // ramp 0,1,2.. rising through 10: window holds 6..21
        capture(0, 100, 100, 0);
        // up then down-ramp from 50, falling through 40 after several wraps
        trig_level = 14'd40; trig_edge = 1'b1;
        capture(1, 70, 50, 0);
        // reset mid-POST, then a fresh capture
        trig_level = 14'd10; trig_edge = 1'b0;
        capture(0, 100, 100, 1);
        capture(0, 80, 50, 0);
        // reset while readout is stalled with a word pending
        capture(0, 100, 100, 2);
        capture(0, 100, 50, 0);
        repeat (6) begin
            trig_ch    = 2'($urandom);
            trig_level = 14'($urandom_range(2000, 14000));
            trig_edge  = 1'($urandom);
            capture(2, $urandom_range(40, 100), $urandom_range(30, 100), 0);
        end
        // level never crossed; only FORCE_TRIG can end WAIT_TRIG
        trig_ch = 2'd1; trig_level = 14'd10; trig_edge = 1'b0;
        capture(3, 100, 100, 3);
        capture(0, 90, 70, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
